// File: rtl/shift_sequencer_if.sv
// Request/grant/result bundle between two requesters and the shift sequencer.
// The master side drives requests and operands; the slave side returns grants and results.
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
);
    logic [1:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [AMT_W-1:0] amt0;
    logic [AMT_W-1:0] amt1;
    logic             mode0;
    logic             mode1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] dout;

    modport master (
        output req, din0, din1, amt0, amt1, mode0, mode1,
        input  gnt, busy, done, done_id, dout
    );

    modport slave (
        input  req, din0, din1, amt0, amt1, mode0, mode1,
        output gnt, busy, done, done_id, dout
    );
endinterface

// File: rtl/shift_sequencer.sv
// Two-requester round-robin arbiter that performs a serial right shift of one bit per cycle.
// Arithmetic or logical fill is selected per request; amounts above WIDTH saturate at WIDTH.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_AMT   = AMT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             id_q, id_d;
    logic             last_q, last_d;

    logic             sel;
    logic [1:0]       gnt;
    logic [WIDTH-1:0] sel_din;
    logic [AMT_W-1:0] sel_amt;
    logic [AMT_W-1:0] amt_clamp;
    logic             sel_mode;

    // On a tie the requester not granted last wins; last_q resets to 1 so requester 0 wins first.
    always_comb begin
        sel = (bus.req == 2'b11) ? ~last_q : bus.req[1];
        gnt = 2'b00;
        if (state_q == IDLE && !rst && bus.req != 2'b00) begin
            gnt = sel ? 2'b10 : 2'b01;
        end
    end

    assign sel_din   = sel ? bus.din1  : bus.din0;
    assign sel_amt   = sel ? bus.amt1  : bus.amt0;
    assign sel_mode  = sel ? bus.mode1 : bus.mode0;
    assign amt_clamp = (sel_amt > WIDTH_AMT) ? WIDTH_AMT : sel_amt;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    data_d  = sel_din;
                    cnt_d   = amt_clamp;
                    mode_d  = sel_mode;
                    id_d    = sel;
                    last_d  = sel;
                    state_d = (amt_clamp == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = {~mode_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                cnt_d  = cnt_q - ONE_AMT;
                if (cnt_q == ONE_AMT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = id_q;
    assign bus.dout    = data_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: shift modes, zero and clamped amounts,
// round-robin alternation and reset abort, with hand-computed expectations.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(16), .AMT_W(5)) bus ();

    shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation starting in an IDLE cycle T: grant at T, done at T+n+1, idle again at T+n+2.
    task automatic run_op(input logic [1:0] reqv, input bit hold, input bit who,
                          input logic [15:0] din, input logic [4:0] amt, input logic mode,
                          input logic [1:0] exp_gnt, input int n,
                          input logic [15:0] exp_dout, input logic exp_id, input string name);
        bus.req = reqv;
        if (who) begin
            bus.din1 = din; bus.amt1 = amt; bus.mode1 = mode;
        end else begin
            bus.din0 = din; bus.amt0 = amt; bus.mode0 = mode;
        end
        #1;
        chk({name, ":gnt"},  32'(bus.gnt),  32'(exp_gnt));
        chk({name, ":idle"}, 32'(bus.busy), 32'd0);
        tick();
        if (!hold) bus.req = reqv & ~exp_gnt;
        // Operand changes after the grant must not disturb the result.
        if (exp_gnt[1]) begin
            bus.din1 = ~din; bus.amt1 = 5'($urandom_range(0, 31)); bus.mode1 = ~mode;
        end else begin
            bus.din0 = ~din; bus.amt0 = 5'($urandom_range(0, 31)); bus.mode0 = ~mode;
        end
        for (int i = 0; i < n; i++) begin
            chk({name, ":shift_busy"}, 32'(bus.busy), 32'd1);
            chk({name, ":shift_done"}, 32'(bus.done), 32'd0);
            chk({name, ":shift_gnt"},  32'(bus.gnt),  32'd0);
            tick();
        end
        chk({name, ":done"},    32'(bus.done),    32'd1);
        chk({name, ":dout"},    32'(bus.dout),    32'(exp_dout));
        chk({name, ":done_id"}, 32'(bus.done_id), 32'(exp_id));
        chk({name, ":done_gnt"}, 32'(bus.gnt),    32'd0);
        $display("op %s: gnt=%b amt=%0d dout=%h done_id=%0d", name, exp_gnt, amt, bus.dout, bus.done_id);
        tick();
        chk({name, ":done_pulse"}, 32'(bus.done), 32'd0);
        chk({name, ":busy_end"},   32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.req   = 2'b11;
        bus.din0  = 16'h0;  bus.din1  = 16'h0;
        bus.amt0  = 5'd0;   bus.amt1  = 5'd0;
        bus.mode0 = 1'b0;   bus.mode1 = 1'b0;
        #1;
        chk("rst:dout",    32'(bus.dout),    32'd0);
        chk("rst:busy",    32'(bus.busy),    32'd0);
        chk("rst:done",    32'(bus.done),    32'd0);
        chk("rst:done_id", 32'(bus.done_id), 32'd0);
        chk("rst:gnt",     32'(bus.gnt),     32'd0);
        bus.req = 2'b00;
        tick();
        tick();
        rst = 1'b0;

        run_op(2'b01, 1'b0, 1'b0, 16'h8000, 5'd3,  1'b0, 2'b01, 3,  16'hF000, 1'b0, "arith3");
        run_op(2'b01, 1'b0, 1'b0, 16'h8000, 5'd3,  1'b1, 2'b01, 3,  16'h1000, 1'b0, "logic3");
        run_op(2'b10, 1'b0, 1'b1, 16'hA5A5, 5'd0,  1'b0, 2'b10, 0,  16'hA5A5, 1'b1, "zero_amt");
        run_op(2'b01, 1'b0, 1'b0, 16'h8000, 5'd20, 1'b0, 2'b01, 16, 16'hFFFF, 1'b0, "clamp_arith");
        run_op(2'b01, 1'b0, 1'b0, 16'h8000, 5'd20, 1'b1, 2'b01, 16, 16'h0000, 1'b0, "clamp_logic");

        // Abort an amt=5 operation two cycles after its grant.
        bus.req = 2'b01; bus.din0 = 16'h1234; bus.amt0 = 5'd5; bus.mode0 = 1'b1;
        #1;
        chk("abort:gnt", 32'(bus.gnt), 32'b01);
        tick();
        bus.req = 2'b00;
        tick();
        chk("abort:busy_pre", 32'(bus.busy), 32'd1);
        bus.req  = 2'b11;
        bus.din0 = 16'h0004; bus.amt0 = 5'd1; bus.mode0 = 1'b1;
        bus.din1 = 16'h8001; bus.amt1 = 5'd1; bus.mode1 = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort:dout",    32'(bus.dout),    32'd0);
        chk("abort:busy",    32'(bus.busy),    32'd0);
        chk("abort:done",    32'(bus.done),    32'd0);
        chk("abort:gnt",     32'(bus.gnt),     32'd0);
        chk("abort:done_id", 32'(bus.done_id), 32'd0);
        $display("op abort: reset applied during shift, dout=%h busy=%0d", bus.dout, bus.busy);
        tick();
        chk("abort:done_hold", 32'(bus.done), 32'd0);
        chk("abort:gnt_hold",  32'(bus.gnt),  32'd0);
        rst = 1'b0;

        run_op(2'b11, 1'b1, 1'b0, 16'h0004, 5'd1, 1'b1, 2'b01, 1, 16'h0002, 1'b0, "rr_a");
        run_op(2'b11, 1'b1, 1'b1, 16'h8001, 5'd1, 1'b0, 2'b10, 1, 16'hC000, 1'b1, "rr_b");
        run_op(2'b11, 1'b1, 1'b0, 16'h0004, 5'd1, 1'b1, 2'b01, 1, 16'h0002, 1'b0, "rr_c");
        bus.req = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
